// File: rtl/hpi_slave_model.sv
// hpi_slave_model
//   Cycle-based responder for the EZ-OTG host-port interface. It decodes the
//   2-bit HPI register select and serves DATA / MAILBOX / ADDRESS / STATUS
//   accesses. DATA accesses go to a local word memory and auto-increment the
//   address. The mailbox is also exposed to a firmware-side port.
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   OTG_DATA[15:0]        HPI data bus, driven only while a read is held
//   OTG_ADDR[1:0]         register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
//   OTG_RD_N/WR_N/CS_N    active-low host strobes
//   OTG_RST_N             active-low chip reset, sampled on Clk
//   mbox_to_host_data/wr  firmware word for the host; wr pulse sets MBX_OUT
//   mbox_from_host        last mailbox word written by the host
//   mbox_from_host_valid  MBX_IN
//   mbox_from_host_ack    pulse clearing MBX_IN
//   hpi_status[15:0]      STATUS register {13'b0, OVF, MBX_IN, MBX_OUT}
module hpi_slave_model #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    inout  logic [15:0] OTG_DATA,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_CS_N,
    input  logic        OTG_RST_N,
    input  logic [15:0] mbox_to_host_data,
    input  logic        mbox_to_host_wr,
    output logic [15:0] mbox_from_host,
    output logic        mbox_from_host_valid,
    input  logic        mbox_from_host_ack,
    output logic [15:0] hpi_status
);

    typedef enum logic [1:0] {IDLE, WR_HOLD, RD_HOLD} state_t;
    typedef enum logic [1:0] {REG_DATA, REG_MBOX, REG_ADDR, REG_STATUS} hpi_reg_t;

    state_t      state, state_d;
    hpi_reg_t    addr_q;
    logic        rd_n_q, wr_n_q, cs_n_q, rst_n_q;
    logic [15:0] data_q;

    logic [15:0] mem [2**MEM_AW];
    logic [15:0] hpi_addr;
    logic [15:0] to_host_word;
    logic [15:0] from_host_word;
    logic [15:0] rd_word;
    logic        mbx_out, mbx_in, ovf;
    logic        blocked;
    logic        rd_is_data;

    logic        int_rst, wr, rd;
    logic        do_wr, do_rd, rd_end;
    logic [MEM_AW-1:0] mem_idx;

    // Input stage is deliberately not reset: a strobe held across reset must
    // stay visible so the blocked-IDLE logic can wait for it to deassert.
    always_ff @(posedge Clk) begin
        addr_q  <= hpi_reg_t'(OTG_ADDR);
        rd_n_q  <= OTG_RD_N;
        wr_n_q  <= OTG_WR_N;
        cs_n_q  <= OTG_CS_N;
        rst_n_q <= OTG_RST_N;
        data_q  <= OTG_DATA;
    end

    assign int_rst = Reset | ~rst_n_q;
    assign wr      = ~cs_n_q & ~wr_n_q &  rd_n_q;
    assign rd      = ~cs_n_q & ~rd_n_q &  wr_n_q;
    assign mem_idx = hpi_addr[MEM_AW:1];

    always_ff @(posedge Clk) begin
        if (int_rst) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        rd_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!blocked) begin
                    if (wr) begin
                        state_d = WR_HOLD;
                        do_wr   = 1'b1;
                    end else if (rd) begin
                        state_d = RD_HOLD;
                        do_rd   = 1'b1;
                    end
                end
            end
            WR_HOLD: if (!wr) state_d = IDLE;
            RD_HOLD: begin
                if (!rd) begin
                    state_d = IDLE;
                    rd_end  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (int_rst) begin
            state_d = IDLE;
            do_wr   = 1'b0;
            do_rd   = 1'b0;
            rd_end  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_wr && addr_q == REG_DATA) mem[mem_idx] <= data_q;
    end

    // Clears are applied before sets so that a same-edge host access and
    // firmware pulse resolve with the set winning.
    always_ff @(posedge Clk) begin
        if (int_rst) begin
            hpi_addr       <= '0;
            to_host_word   <= '0;
            from_host_word <= '0;
            rd_word        <= '0;
            mbx_out        <= 1'b0;
            mbx_in         <= 1'b0;
            ovf            <= 1'b0;
            rd_is_data     <= 1'b0;
            blocked        <= 1'b1;
        end else begin
            if (!wr && !rd) blocked <= 1'b0;
            if (mbox_from_host_ack) mbx_in <= 1'b0;
            if (mbox_to_host_wr) to_host_word <= mbox_to_host_data;

            if (do_wr) begin
                case (addr_q)
                    REG_DATA:   hpi_addr <= hpi_addr + 16'd2;
                    REG_MBOX: begin
                        from_host_word <= data_q;
                        mbx_in         <= 1'b1;
                        if (mbx_in && !mbox_from_host_ack) ovf <= 1'b1;
                    end
                    REG_ADDR:   hpi_addr <= data_q;
                    REG_STATUS: if (data_q[2]) ovf <= 1'b0;
                    default: ;
                endcase
            end

            if (do_rd) begin
                rd_is_data <= (addr_q == REG_DATA);
                case (addr_q)
                    REG_DATA:   rd_word <= mem[mem_idx];
                    REG_MBOX: begin
                        rd_word <= to_host_word;
                        mbx_out <= 1'b0;
                    end
                    REG_ADDR:   rd_word <= hpi_addr;
                    REG_STATUS: rd_word <= hpi_status;
                    default: ;
                endcase
            end

            if (rd_end && rd_is_data) hpi_addr <= hpi_addr + 16'd2;
            if (mbox_to_host_wr) mbx_out <= 1'b1;
        end
    end

    assign hpi_status           = {13'd0, ovf, mbx_in, mbx_out};
    assign mbox_from_host       = from_host_word;
    assign mbox_from_host_valid = mbx_in;
    assign OTG_DATA             = (state == RD_HOLD) ? rd_word : 'z;

endmodule

// File: tb/tb_hpi_slave_model.sv
module tb_hpi_slave_model;

    logic        Clk = 1'b0;
    logic        Reset;
    tri1  [15:0] OTG_DATA;
    logic [1:0]  OTG_ADDR;
    logic        OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N;
    logic [15:0] mbox_to_host_data;
    logic        mbox_to_host_wr;
    logic [15:0] mbox_from_host;
    logic        mbox_from_host_valid;
    logic        mbox_from_host_ack;
    logic [15:0] hpi_status;

    logic        tb_drv_en;
    logic [15:0] tb_drv;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    bit          done = 1'b0;

    localparam logic [1:0] A_DATA = 2'd0, A_MBOX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

    assign OTG_DATA = tb_drv_en ? tb_drv : 'z;

    always #5 Clk = ~Clk;

    hpi_slave_model #(.MEM_AW(8)) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .OTG_DATA             (OTG_DATA),
        .OTG_ADDR             (OTG_ADDR),
        .OTG_RD_N             (OTG_RD_N),
        .OTG_WR_N             (OTG_WR_N),
        .OTG_CS_N             (OTG_CS_N),
        .OTG_RST_N            (OTG_RST_N),
        .mbox_to_host_data    (mbox_to_host_data),
        .mbox_to_host_wr      (mbox_to_host_wr),
        .mbox_from_host       (mbox_from_host),
        .mbox_from_host_valid (mbox_from_host_valid),
        .mbox_from_host_ack   (mbox_from_host_ack),
        .hpi_status           (hpi_status)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the bus is pulled up, so any value other than 16'hFFFF while
    // the bench is not driving means the DUT has started a read response.
    initial begin : monitor
        bit drv, drv_prev;
        logic [15:0] e;
        drv_prev = 1'b0;
        while (!done) begin
            @(negedge Clk);
            drv = !tb_drv_en && (OTG_DATA != 16'hFFFF);
            if (drv && !drv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_drive: got %h expected high-Z", OTG_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", OTG_DATA, e);
                end
            end
            drv_prev = drv;
        end
    end

    // One host access; optional firmware pulses land on the commit/latch edge.
    task automatic access(input bit is_rd, input logic [1:0] a, input logic [15:0] d,
                          input int unsigned hold, input bit ack_p, input bit th_p,
                          input logic [15:0] th_d);
        @(negedge Clk);
        OTG_ADDR = a;
        OTG_CS_N = 1'b0;
        if (is_rd) OTG_RD_N = 1'b0;
        else begin
            OTG_WR_N  = 1'b0;
            tb_drv_en = 1'b1;
            tb_drv    = d;
        end
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                mbox_from_host_ack = ack_p;
                mbox_to_host_wr    = th_p;
                mbox_to_host_data  = th_d;
            end else begin
                mbox_from_host_ack = 1'b0;
                mbox_to_host_wr    = 1'b0;
            end
        end
        OTG_CS_N  = 1'b1;
        OTG_RD_N  = 1'b1;
        OTG_WR_N  = 1'b1;
        tb_drv_en = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic hwr(input logic [1:0] a, input logic [15:0] d);
        access(1'b0, a, d, 4, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic hrd(input logic [1:0] a, input logic [15:0] exp);
        exp_q.push_back(exp);
        access(1'b1, a, 16'h0, 4, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic fw_to_host(input logic [15:0] d);
        @(negedge Clk);
        mbox_to_host_data = d;
        mbox_to_host_wr   = 1'b1;
        @(negedge Clk);
        mbox_to_host_wr   = 1'b0;
        @(negedge Clk);
    endtask

    task automatic fw_ack();
        @(negedge Clk);
        mbox_from_host_ack = 1'b1;
        @(negedge Clk);
        mbox_from_host_ack = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        OTG_ADDR = 2'd0;
        OTG_RD_N = 1'b1; OTG_WR_N = 1'b1; OTG_CS_N = 1'b1; OTG_RST_N = 1'b1;
        mbox_to_host_data = 16'h0; mbox_to_host_wr = 1'b0; mbox_from_host_ack = 1'b0;
        tb_drv_en = 1'b0; tb_drv = 16'h0;
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_status", hpi_status, 16'h0000);
        check("rst_mbox", mbox_from_host, 16'h0000);
        check("rst_valid", {15'd0, mbox_from_host_valid}, 16'h0000);
        check("rst_bus_z", OTG_DATA, 16'hFFFF);

        // Basic DATA write/read with auto-increment
        hwr(A_ADDR, 16'h0010);
        hwr(A_DATA, 16'hA5A5);
        hwr(A_DATA, 16'h5A5A);
        hwr(A_ADDR, 16'h0010);
        hrd(A_DATA, 16'hA5A5);
        hrd(A_DATA, 16'h5A5A);
        hrd(A_ADDR, 16'h0014);

        // Long-held write commits once
        access(1'b0, A_DATA, 16'h1111, 10, 1'b0, 1'b0, 16'h0);
        hrd(A_ADDR, 16'h0016);
        hwr(A_DATA, 16'h2222);
        hwr(A_ADDR, 16'h0014);
        hrd(A_DATA, 16'h1111);
        hrd(A_DATA, 16'h2222);
        hrd(A_ADDR, 16'h0018);

        // Host -> firmware mailbox, overflow, clears
        hwr(A_MBOX, 16'h1234);
        check("mbx_word1", mbox_from_host, 16'h1234);
        check("mbx_valid1", {15'd0, mbox_from_host_valid}, 16'h0001);
        check("mbx_status1", hpi_status, 16'h0002);
        hwr(A_MBOX, 16'h5678);
        check("mbx_ovf", hpi_status, 16'h0006);
        check("mbx_word2", mbox_from_host, 16'h5678);
        hrd(A_STAT, 16'h0006);
        hwr(A_STAT, 16'h0004);
        check("ovf_clear", hpi_status, 16'h0002);
        fw_ack();
        check("ack_clear", hpi_status, 16'h0000);
        check("ack_valid", {15'd0, mbox_from_host_valid}, 16'h0000);
        hwr(A_MBOX, 16'h1111);
        access(1'b0, A_MBOX, 16'h2222, 4, 1'b1, 1'b0, 16'h0);
        check("ack_vs_write_status", hpi_status, 16'h0002);
        check("ack_vs_write_word", mbox_from_host, 16'h2222);
        fw_ack();

        // Firmware -> host mailbox, set wins over read clear
        fw_to_host(16'hBEEF);
        check("mbx_out_set", hpi_status, 16'h0001);
        hrd(A_MBOX, 16'hBEEF);
        check("mbx_out_clr", hpi_status, 16'h0000);
        fw_to_host(16'hBEEF);
        exp_q.push_back(16'hBEEF);
        access(1'b1, A_MBOX, 16'h0, 4, 1'b0, 1'b1, 16'hCAFE);
        check("mbx_out_set_wins", hpi_status, 16'h0001);
        hrd(A_MBOX, 16'hCAFE);
        check("mbx_out_clr2", hpi_status, 16'h0000);

        // Address wrap, aliasing, bit0 storage
        hwr(A_ADDR, 16'hFFFE);
        hwr(A_DATA, 16'h3333);
        hrd(A_ADDR, 16'h0000);
        hwr(A_ADDR, 16'h01FE);
        hrd(A_DATA, 16'h3333);
        hwr(A_ADDR, 16'h0011);
        hrd(A_ADDR, 16'h0011);
        hrd(A_DATA, 16'hA5A5);

        // Illegal strobe combination: no commit, no drive
        @(negedge Clk);
        OTG_ADDR = A_DATA;
        OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_WR_N = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("illegal_bus_z", OTG_DATA, 16'hFFFF);
        end
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
        repeat (3) @(negedge Clk);
        check("illegal_status", hpi_status, 16'h0000);
        hrd(A_ADDR, 16'h0013);
        hwr(A_ADDR, 16'h0012);
        hrd(A_DATA, 16'h5A5A);

        // Chip reset via OTG_RST_N
        fw_to_host(16'hBEEF);
        hwr(A_MBOX, 16'h4321);
        check("pre_otgrst_status", hpi_status, 16'h0003);
        @(negedge Clk);
        OTG_RST_N = 1'b0;
        @(negedge Clk);
        OTG_RST_N = 1'b1;
        repeat (2) @(negedge Clk);
        check("otgrst_status", hpi_status, 16'h0000);
        check("otgrst_mbox", mbox_from_host, 16'h0000);
        hrd(A_MBOX, 16'h0000);

        // Reset during a held read; held strobe ignored after release
        hwr(A_MBOX, 16'h7777);
        hwr(A_ADDR, 16'h0012);
        exp_q.push_back(16'h5A5A);
        @(negedge Clk);
        OTG_ADDR = A_DATA;
        OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        repeat (4) @(negedge Clk);
        check("midread_driven", OTG_DATA, 16'h5A5A);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_bus_z", OTG_DATA, 16'hFFFF);
        check("midrst_status", hpi_status, 16'h0000);
        check("midrst_mbox", mbox_from_host, 16'h0000);
        check("midrst_valid", {15'd0, mbox_from_host_valid}, 16'h0000);
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge Clk);
            check("blocked_bus_z", OTG_DATA, 16'hFFFF);
        end
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
        repeat (3) @(negedge Clk);
        hrd(A_ADDR, 16'h0000);
        hwr(A_ADDR, 16'h0012);
        hrd(A_DATA, 16'h5A5A);

        repeat (3) @(negedge Clk);
        check("sb_drain", 16'(exp_q.size()), 16'h0000);
        done = 1'b1;
        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpi_slave_model.md
# hpi_slave_model

Cycle-based model of the EZ-OTG host-port-interface (HPI) responder: the chip-side end of the 16-bit HPI bus that the NIOS-side HPI interface drives. It decodes the 2-bit HPI register address, serves DATA/MAILBOX/ADDRESS/STATUS accesses against a local word memory with address auto-increment, and exposes the mailbox to a local firmware-side port. It is used for simulation and for on-board loopback in place of the USB chip.

## Interface
- MEM_AW, 8: word-address width of the internal memory (2^MEM_AW x 16 bits).
- Clk  input  1  clock
- Reset  input  1  reset, synchronous, active-high
- OTG_DATA  inout  16  HPI data bus; driven only during a read
- OTG_ADDR  input  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- OTG_RD_N, OTG_WR_N, OTG_CS_N  input  1 each  active-low strobes
- OTG_RST_N  input  1  active-low chip reset, sampled synchronously
- mbox_to_host_data  input  16  firmware-side mailbox word for the host
- mbox_to_host_wr  input  1  one-cycle pulse: load mbox_to_host_data, set MBX_OUT
- mbox_from_host  output  16  last mailbox word written by the host
- mbox_from_host_valid  output  1  equals STATUS bit1 (MBX_IN)
- mbox_from_host_ack  input  1  one-cycle pulse: clear MBX_IN
- hpi_status  output  16  current STATUS register

## Operation
- Input stage: OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, and OTG_DATA are registered once on Clk. All decode uses these registered copies.
- Access classes, evaluated on the registered strobes:
  - wr = CS_N=0 and WR_N=0 and RD_N=1.
  - rd = CS_N=0 and RD_N=0 and WR_N=1.
  - CS_N=0 with both RD_N and WR_N low is illegal. It is treated as idle: no commit and no drive.
- FSM states: IDLE, WR_HOLD, RD_HOLD.
  - IDLE -> WR_HOLD on wr, committing the write on that edge.
  - IDLE -> RD_HOLD on rd, latching read data on that edge.
  - WR_HOLD -> IDLE when wr drops.
  - RD_HOLD -> IDLE when rd drops; a DATA read auto-increments ADDRESS on that edge.
  - Exactly one commit occurs per strobe assertion, however many cycles it is held.
- Write commits:
  - DATA writes mem[ADDRESS[MEM_AW:1]], then ADDRESS += 2 on the same edge.
  - MAILBOX loads mbox_from_host and sets MBX_IN. If MBX_IN was already set, it also sets OVF.
  - ADDRESS loads the full 16-bit value; bit0 is stored but ignored for indexing.
  - STATUS: writing 1 to bit2 clears OVF; all other bits are ignored.
- Read latch:
  - DATA returns mem[ADDRESS[MEM_AW:1]].
  - MAILBOX returns the to-host word and clears MBX_OUT.
  - ADDRESS returns the current address.
  - STATUS returns hpi_status.
- STATUS layout: bit0 MBX_OUT, bit1 MBX_IN, bit2 OVF (sticky); bits 15:3 read 0.
- ADDRESS arithmetic is 16-bit and wraps 0xFFFE -> 0x0000. Memory indexes only bits MEM_AW:1, so it aliases above 2^(MEM_AW+1) bytes.
- Bus drive: OTG_DATA is driven from the registered read word while the state is RD_HOLD; otherwise it is 16'hzzzz.
- Simultaneous events:
  - mbox_to_host_wr in the same cycle as a host MAILBOX read: the host gets the old word, and MBX_OUT ends set with the new word (set wins).
  - mbox_from_host_ack in the same cycle as a host MAILBOX write: MBX_IN ends set, OVF is not set, and the new word is stored.
- Reset, or registered OTG_RST_N=0, has the same effect even mid-access:
  - FSM -> IDLE, OTG_DATA high-Z.
  - ADDRESS=0, STATUS=0, mbox_from_host=0, mbox_from_host_valid=0, hpi_status=0, to-host word=0.
  - Memory contents are not reset.
  - A strobe still held low when reset releases is ignored until it deasserts (the FSM waits in a blocked IDLE).

## Timing
- Latency from a strobe change at the pins: 1 cycle to the input register, commit/latch on the next edge (2 cycles total).
- OTG_DATA is valid 2 cycles after RD_N/CS_N fall at the pins, and returns to high-Z 2 cycles after either rises.
- The host must hold each strobe for at least 3 Clk and keep address/data stable throughout. Back-to-back accesses need at least 1 idle cycle between strobes.
- Status and mailbox outputs update on the commit edge. The firmware-side ack and wr pulses take effect on the next edge.

## Test plan
- Reset, then write ADDRESS=0x0010 and DATA 0xA5A5, 0x5A5A, then ADDRESS=0x0010 and two DATA reads -> reads return 0xA5A5 then 0x5A5A; ADDRESS reads 0x0014.
- Hold a DATA write strobe for 10 cycles -> exactly one memory write and one +2 increment.
- Host MAILBOX write 0x1234 -> mbox_from_host=0x1234, valid=1. A second write 0x5678 before ack -> STATUS=0x0006. STATUS write 0x0004 -> OVF cleared. Ack -> STATUS=0x0000.
- Pulse mbox_to_host_wr with 0xBEEF -> STATUS bit0=1. MAILBOX read returns 0xBEEF and clears bit0. A same-cycle pulse with 0xCAFE during the read -> read still 0xBEEF, bit0 stays 1.
- ADDRESS=0xFFFE then a DATA write -> ADDRESS wraps to 0x0000. Drive RD_N=WR_N=CS_N=0 -> OTG_DATA stays high-Z and no state changes.
- Assert Reset mid read -> OTG_DATA high-Z next cycle and STATUS/ADDRESS = 0. A strobe still held low after release causes no access until it deasserts.
